axi_bram_slave: RTL and testbench

//  AXI3 slave memory model on the accelerator's M_AXI master port; replaces tied-off AXI inputs in top-level builds.

---
 rtl/axi_bram_slave_pkg.sv | 27 ++
 rtl/axi_bram_slave_if.sv | 67 ++++++
 rtl/axi_bram_slave_ram.sv | 32 +++
 rtl/axi_bram_slave.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_bram_slave.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_bram_slave_pkg.sv
// Shared constants and state types for the AXI3 BRAM slave memory model.
package axi_bram_slave_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_e;

  // WRAP is served like INCR (linear, no wrap boundary); FIXED holds the address.
  function automatic logic burst_advances(input logic [1:0] burst);
    return (burst == AXI_BURST_INCR) || (burst == AXI_BURST_WRAP);
  endfunction

endpackage

// File: rtl/axi_bram_slave_if.sv
// AXI3 subset seen by the BRAM slave: AW/W/B/AR/R handshakes with ID, address, length and burst.
interface axi_bram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6
);

  logic [ID_W-1:0]     s_awid;
  logic [ADDR_W-1:0]   s_awaddr;
  logic [3:0]          s_awlen;
  logic [1:0]          s_awburst;
  logic                s_awvalid;
  logic                s_awready;

  logic [ID_W-1:0]     s_wid;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wlast;
  logic                s_wvalid;
  logic                s_wready;

  logic [ID_W-1:0]     s_bid;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;

  logic [ID_W-1:0]     s_arid;
  logic [ADDR_W-1:0]   s_araddr;
  logic [3:0]          s_arlen;
  logic [1:0]          s_arburst;
  logic                s_arvalid;
  logic                s_arready;

  logic [ID_W-1:0]     s_rid;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rlast;
  logic                s_rvalid;
  logic                s_rready;

  modport master (
    output s_awid, s_awaddr, s_awlen, s_awburst, s_awvalid,
    input  s_awready,
    output s_wid, s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    output s_arid, s_araddr, s_arlen, s_arburst, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output s_rready
  );

  modport slave (
    input  s_awid, s_awaddr, s_awlen, s_awburst, s_awvalid,
    output s_awready,
    input  s_wid, s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    input  s_arid, s_araddr, s_arlen, s_arburst, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  s_rready
  );

endinterface

// File: rtl/axi_bram_slave_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port, read-first.
module axi_bram_slave_ram #(
  parameter int DATA_W     = 64,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [MEM_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [MEM_ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1<<MEM_ADDR_W)-1];

  // Byte-lane writes; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; a same-cycle write to the same word is seen on the next read.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_bram_slave.sv
// AXI3 slave memory model: independent write and read FSMs streaming INCR/FIXED bursts
// into a dual-port RAM, with SLVERR for beats outside the window and beat counters.
module axi_bram_slave
  import axi_bram_slave_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 64,
  parameter int                ID_W       = 6,
  parameter int                MEM_ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_bram_slave_if.slave      bus,
  output logic [31:0]          wr_beat_count,
  output logic [31:0]          rd_beat_count
);

  localparam int                BYTES = DATA_W / 8;
  localparam int                SHIFT = $clog2(BYTES);
  localparam logic [ADDR_W:0]   WIN   = (ADDR_W+1)'(1) << (MEM_ADDR_W + SHIFT);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BYTES);

  // Beat is served only when its offset from the base lies inside the RAM window.
  function automatic logic in_window(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return {1'b0, off} < WIN;
  endfunction

  // Word index drops the byte-offset bits; callers only use it for in-window beats.
  function automatic logic [MEM_ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off[SHIFT +: MEM_ADDR_W];
  endfunction

  // ---------------- write channel state ----------------
  wr_state_e          w_state;
  logic               awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0]    aw_id, bid_q;
  logic [ADDR_W-1:0]  aw_addr;
  logic [3:0]         aw_len, w_cnt;
  logic [1:0]         aw_burst, bresp_q;
  logic               w_err;

  logic               w_fire, w_inr, w_last_beat, w_err_nx;

  // ---------------- read channel state ----------------
  rd_state_e          r_state;
  logic               arready_q, rvalid_q, rlast_q, r_oor_q, r_all;
  logic [ID_W-1:0]    ar_id, rid_q;
  logic [ADDR_W-1:0]  ar_addr;
  logic [3:0]         ar_len, r_cnt;
  logic [1:0]         ar_burst, rresp_q;

  logic               r_inr, r_issue;
  logic [DATA_W-1:0]  ram_q;

  logic               unused_wid;
  assign unused_wid = ^bus.s_wid;

  // Current write beat: range check and accumulated error including wlast position.
  always_comb begin
    w_fire      = bus.s_wvalid && wready_q;
    w_inr       = in_window(aw_addr);
    w_last_beat = (w_cnt == aw_len);
    w_err_nx    = w_err || !w_inr || (bus.s_wlast != w_last_beat);
  end

  // Write FSM: accept AW, count W beats (wlast never terminates early), then hold B.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= AXI_RESP_OKAY;
      aw_id     <= '0;
      aw_addr   <= '0;
      aw_len    <= '0;
      aw_burst  <= AXI_BURST_FIXED;
      w_cnt     <= '0;
      w_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (bus.s_awvalid) begin
            aw_id     <= bus.s_awid;
            aw_addr   <= bus.s_awaddr;
            aw_len    <= bus.s_awlen;
            aw_burst  <= bus.s_awburst;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_err <= w_err_nx;
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= aw_id;
              bresp_q  <= w_err_nx ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              w_state  <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 4'd1;
              if (burst_advances(aw_burst)) aw_addr <= aw_addr + STEP;
            end
          end
        end
        W_RESP: begin
          if (bus.s_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: begin
          w_state   <= W_IDLE;
          awready_q <= 1'b1;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next read beat may be fetched when the output slot is empty or being drained.
  always_comb begin
    r_inr   = in_window(ar_addr);
    r_issue = (r_state == R_BURST) && !r_all && (!rvalid_q || bus.s_rready);
  end

  // Read FSM: the R slot registers follow each RAM fetch and hold while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= AXI_RESP_OKAY;
      rid_q     <= '0;
      r_oor_q   <= 1'b0;
      r_all     <= 1'b0;
      ar_id     <= '0;
      ar_addr   <= '0;
      ar_len    <= '0;
      ar_burst  <= AXI_BURST_FIXED;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bus.s_arvalid) begin
            ar_id     <= bus.s_arid;
            ar_addr   <= bus.s_araddr;
            ar_len    <= bus.s_arlen;
            ar_burst  <= bus.s_arburst;
            r_cnt     <= '0;
            r_all     <= 1'b0;
            arready_q <= 1'b0;
            r_state   <= R_BURST;
          end
        end
        R_BURST: begin
          if (r_issue) begin
            rvalid_q <= 1'b1;
            rid_q    <= ar_id;
            rlast_q  <= (r_cnt == ar_len);
            rresp_q  <= r_inr ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            r_oor_q  <= !r_inr;
            if (r_cnt == ar_len) begin
              r_all <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
              if (burst_advances(ar_burst)) ar_addr <= ar_addr + STEP;
            end
          end else if (rvalid_q && bus.s_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end
          end
        end
        default: begin
          r_state   <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
        end
      endcase
    end
  end

  // Beat counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_beat_count <= '0;
      rd_beat_count <= '0;
    end else begin
      if (w_fire)                      wr_beat_count <= wr_beat_count + 32'd1;
      if (rvalid_q && bus.s_rready)    rd_beat_count <= rd_beat_count + 32'd1;
    end
  end

  axi_bram_slave_ram #(
    .DATA_W     (DATA_W),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_fire && w_inr),
    .wbe   (bus.s_wstrb),
    .waddr (word_index(aw_addr)),
    .wdata (bus.s_wdata),
    .re    (r_issue && r_inr),
    .raddr (word_index(ar_addr)),
    .rdata (ram_q)
  );

  assign bus.s_awready = awready_q;
  assign bus.s_wready  = wready_q;
  assign bus.s_bvalid  = bvalid_q;
  assign bus.s_bid     = bid_q;
  assign bus.s_bresp   = bresp_q;
  assign bus.s_arready = arready_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rid     = rid_q;
  assign bus.s_rresp   = rresp_q;
  assign bus.s_rlast   = rlast_q;
  // Out-of-window beats and the idle slot both present zero data.
  assign bus.s_rdata   = (rvalid_q && !r_oor_q) ? ram_q : '0;

endmodule

// File: tb/tb_axi_bram_slave.sv
// Scoreboard bench for axi_bram_slave: directed scenarios plus randomized bursts
// checked against a byte-level memory model.
module tb_axi_bram_slave;

  localparam int          ADDR_W     = 32;
  localparam int          DATA_W     = 64;
  localparam int          ID_W       = 6;
  localparam int          MEM_ADDR_W = 12;
  localparam logic [31:0] BASE       = 32'h0000_0000;
  localparam logic [31:0] WIN        = 32'd32768;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  axi_bram_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus();
  logic [31:0] wr_beat_count, rd_beat_count;

  axi_bram_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .MEM_ADDR_W(MEM_ADDR_W), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset_n), .bus(bus),
    .wr_beat_count(wr_beat_count), .rd_beat_count(rd_beat_count)
  );

  typedef struct {
    logic [5:0]  id;
    logic [63:0] data;
    logic [63:0] mask;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  rexp_t       rq[$];
  logic [7:0]  bq[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned exp_wr = 0;
  int unsigned exp_rd = 0;
  int          rr_mode = 0;

  logic [63:0] mdl    [4096];
  logic [7:0]  mdl_bv [4096];
  logic [63:0] wbuf   [16];
  logic [7:0]  sbuf   [16];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a : a + 32'(8 * i);
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < WIN;
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 3);
  endfunction

  function automatic logic [63:0] bytemask(input logic [7:0] bv);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{bv[b]}};
    return m;
  endfunction

  function automatic bit rdy(input int ch);
    case (ch)
      0:       return bus.s_awready;
      1:       return bus.s_wready;
      default: return bus.s_arready;
    endcase
  endfunction

  // Waits (bounded) until the selected ready is seen high before an edge, then passes that edge.
  task automatic handshake(input int ch, input string nm);
    int t = 0;
    @(negedge clk);
    while (!rdy(ch) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk(nm, 128'(rdy(ch)), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    int t = 0;
    while (bq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("b_drain_timeout", 128'(bq.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_r();
    int t = 0;
    while (rq.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) chk("r_drain_timeout", 128'(rq.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  // Write burst from wbuf/sbuf; bad_last marks a beat whose wlast is inverted.
  task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input int bad_last, input bit gaps);
    bit err = 0;
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a;
      a = beat_addr(addr, burst, i);
      if (in_win(a)) begin
        for (int b = 0; b < 8; b++) begin
          if (sbuf[i][b]) begin
            mdl[widx(a)][b*8 +: 8] = wbuf[i][b*8 +: 8];
            mdl_bv[widx(a)][b]     = 1'b1;
          end
        end
      end else begin
        err = 1;
      end
      if (i == bad_last) err = 1;
    end
    bq.push_back({id, err ? 2'b10 : 2'b00});
    exp_wr += int'(len) + 1;

    bus.s_awid = id; bus.s_awaddr = addr; bus.s_awlen = len; bus.s_awburst = burst;
    bus.s_awvalid = 1'b1;
    handshake(0, "awready_timeout");
    bus.s_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      bus.s_wid = id; bus.s_wdata = wbuf[i]; bus.s_wstrb = sbuf[i];
      bus.s_wlast = (i == int'(len)) ^ (i == bad_last);
      bus.s_wvalid = 1'b1;
      handshake(1, "wready_timeout");
      bus.s_wvalid = 1'b0;
      bus.s_wlast  = 1'b0;
    end
    drain_b();
  endtask

  task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input bit chk_lat);
    for (int i = 0; i <= int'(len); i++) begin
      rexp_t e;
      logic [31:0] a;
      a = beat_addr(addr, burst, i);
      e.id = id;
      e.last = (i == int'(len));
      if (in_win(a)) begin
        e.data = mdl[widx(a)];
        e.mask = bytemask(mdl_bv[widx(a)]);
        e.resp = 2'b00;
      end else begin
        e.data = 64'h0;
        e.mask = {64{1'b1}};
        e.resp = 2'b10;
      end
      rq.push_back(e);
    end
    exp_rd += int'(len) + 1;

    bus.s_arid = id; bus.s_araddr = addr; bus.s_arlen = len; bus.s_arburst = burst;
    bus.s_arvalid = 1'b1;
    handshake(2, "arready_timeout");
    bus.s_arvalid = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      @(negedge clk);
      chk("r_first_beat_latency", 128'(bus.s_rvalid), 128'd1);
      repeat (int'(len) + 1) @(negedge clk);
      chk("r_stream_back_to_back", {bus.s_rvalid, 32'(rq.size())}, 128'd0);
    end
    drain_r();
  endtask

  // Write response monitor.
  always @(negedge clk) begin
    if (reset_n && bus.s_bvalid && bus.s_bready) begin
      if (bq.size() == 0) begin
        chk("b_unexpected", 128'(bus.s_bvalid), 128'd0);
      end else begin
        logic [7:0] e;
        e = bq.pop_front();
        chk("b_id_resp", {bus.s_bid, bus.s_bresp}, 128'(e));
      end
    end
  end

  // Read data monitor, including stability of a stalled beat.
  logic        hv = 1'b0;
  logic [72:0] hd;
  always @(negedge clk) begin
    if (!reset_n) begin
      hv <= 1'b0;
    end else begin
      if (hv)
        chk("r_stall_hold", {bus.s_rvalid, bus.s_rid, bus.s_rdata, bus.s_rresp, bus.s_rlast}, {1'b1, hd});
      if (bus.s_rvalid && bus.s_rready) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 128'(bus.s_rvalid), 128'd0);
        end else begin
          rexp_t e;
          e = rq.pop_front();
          chk("r_beat", {bus.s_rid, bus.s_rresp, bus.s_rlast, bus.s_rdata & e.mask},
                        {e.id, e.resp, e.last, e.data & e.mask});
        end
      end
      hv <= bus.s_rvalid && !bus.s_rready;
      hd <= {bus.s_rid, bus.s_rdata, bus.s_rresp, bus.s_rlast};
    end
  end

  // Response-side ready drivers.
  initial begin
    bus.s_bready = 1'b0;
    bus.s_rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.s_bready = ($urandom_range(0, 3) != 0);
      case (rr_mode)
        0:       bus.s_rready = 1'b1;
        1:       bus.s_rready = ~bus.s_rready;
        default: bus.s_rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mdl_bv[i] = 8'h00;
    bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awburst = '0; bus.s_awvalid = 1'b0;
    bus.s_wid = '0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 1'b0; bus.s_wvalid = 1'b0;
    bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arburst = '0; bus.s_arvalid = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", {bus.s_awready, bus.s_arready, bus.s_wready}, 128'b110);
    chk("rst_valid", {bus.s_bvalid, bus.s_rvalid, bus.s_rlast}, 128'd0);
    chk("rst_counts", {wr_beat_count, rd_beat_count}, 128'd0);
    chk("rst_rdata", 128'(bus.s_rdata), 128'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {bus.s_awready, bus.s_arready, bus.s_bvalid, bus.s_rvalid}, 128'b1100);
    @(posedge clk);
    #1;

    // INCR burst at 0x40, data 1..4, then full-rate read back.
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i + 1); sbuf[i] = 8'hFF; end
    rr_mode = 0;
    do_write(6'h2A, 32'h40, 4'd3, 2'b01, -1, 1'b0);
    do_read(6'h15, 32'h40, 4'd3, 2'b01, 1'b1);
    chk("rd_count_after_first", 128'(rd_beat_count), 128'd4);

    // Byte strobes: all-ones then low-half zero.
    wbuf[0] = {64{1'b1}}; sbuf[0] = 8'hFF;
    do_write(6'h01, 32'h28, 4'd0, 2'b01, -1, 1'b0);
    wbuf[0] = 64'h0; sbuf[0] = 8'h0F;
    do_write(6'h02, 32'h28, 4'd0, 2'b01, -1, 1'b0);
    do_read(6'h03, 32'h28, 4'd0, 2'b01, 1'b0);

    // len-15 read with rready toggling.
    for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    do_write(6'h04, 32'h1000, 4'd15, 2'b01, -1, 1'b1);
    rr_mode = 1;
    do_read(6'h05, 32'h1000, 4'd15, 2'b01, 1'b0);

    // Burst crossing the top of the window.
    wbuf[0] = 64'hA5A5_0000_1111_2222; wbuf[1] = 64'h5A5A_3333_4444_5555;
    sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    rr_mode = 2;
    do_write(6'h06, WIN - 32'd8, 4'd1, 2'b01, -1, 1'b0);
    do_read(6'h07, WIN - 32'd8, 4'd1, 2'b01, 1'b0);

    // wlast early, then wlast missing: count-terminated, SLVERR.
    for (int i = 0; i < 3; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    do_write(6'h08, 32'h2000, 4'd2, 2'b01, 1, 1'b0);
    do_write(6'h09, 32'h2100, 4'd2, 2'b01, 2, 1'b0);
    do_read(6'h0A, 32'h2000, 4'd2, 2'b01, 1'b0);
    do_read(6'h0B, 32'h2100, 4'd2, 2'b01, 1'b0);

    // FIXED burst keeps rewriting one word.
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'(1 << i) | 8'h10; end
    do_write(6'h0C, 32'h300, 4'd3, 2'b00, -1, 1'b1);
    do_read(6'h0D, 32'h300, 4'd2, 2'b00, 1'b0);

    // Randomized bursts.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      logic [3:0]  len;
      logic [1:0]  burst;
      int          bl;
      case ($urandom_range(0, 5))
        0:       a = WIN - 32'(8 * $urandom_range(0, 8)) + 32'($urandom_range(0, 7));
        1:       a = 32'h8000_0000 | 32'($urandom_range(0, 255));
        default: a = {17'h0, 12'($urandom_range(0, 4095)), 3'($urandom_range(0, 7))};
      endcase
      len   = 4'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 2));
      bl    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1;
      for (int i = 0; i < 16; i++) begin
        wbuf[i] = {$urandom, $urandom};
        sbuf[i] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      end
      rr_mode = int'($urandom_range(0, 2));
      do_write(6'($urandom_range(0, 63)), a, len, burst, bl, 1'b1);
      do_read(6'($urandom_range(0, 63)), a, 4'($urandom_range(0, 15)), burst, 1'b0);
    end
    chk("wr_beat_count", 128'(wr_beat_count), 128'(exp_wr));
    chk("rd_beat_count", 128'(rd_beat_count), 128'(exp_rd));

    // Reset in the middle of a 4-beat write: beat 1 lands, no response follows.
    wbuf[0] = 64'h1111_1111_1111_1111; wbuf[1] = 64'h2222_2222_2222_2222;
    sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    rr_mode = 0;
    do_write(6'h10, 32'h200, 4'd1, 2'b01, -1, 1'b0);
    bus.s_awid = 6'h11; bus.s_awaddr = 32'h200; bus.s_awlen = 4'd3; bus.s_awburst = 2'b01;
    bus.s_awvalid = 1'b1;
    handshake(0, "awready_timeout");
    bus.s_awvalid = 1'b0;
    bus.s_wdata = 64'hDEAD_BEEF_0BAD_F00D; bus.s_wstrb = 8'hFF; bus.s_wlast = 1'b0; bus.s_wvalid = 1'b1;
    handshake(1, "wready_timeout");
    mdl[widx(32'h200)] = 64'hDEAD_BEEF_0BAD_F00D;
    bus.s_wdata = 64'hCAFE_CAFE_CAFE_CAFE;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus.s_awready, bus.s_wready, bus.s_bvalid}, 128'b100);
    @(posedge clk);
    #1 bus.s_wvalid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_wr = 0;
    exp_rd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_mid_no_bvalid", {bus.s_bvalid, bus.s_awready}, 128'b01);
    end
    chk("rst_mid_wr_count", 128'(wr_beat_count), 128'd0);
    @(posedge clk);
    #1;
    do_read(6'h12, 32'h200, 4'd1, 2'b01, 1'b0);
    chk("rd_count_after_rst", 128'(rd_beat_count), 128'(exp_rd));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
